// File: rtl/osd_multi_field_writer.sv
// OSD write sequencer: optional full-buffer clear, then NUM_FIELDS hex fields rendered
// one per row, streamed to the VRAM write port over a valid/ready handshake.
module osd_multi_field_writer #(
  parameter int COLS       = 40,
  parameter int ROWS       = 30,
  parameter int WIDTH_BITS = 16,
  parameter int NUM_FIELDS = 4,
  parameter int VAL_W      = 16,
  parameter int FIELD_ROW  = 2,
  parameter int FIELD_COL  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        osd_writer_start_init,
  input  logic                        osd_writer_clear_en,
  input  logic [7:0]                  osd_writer_clear_char,
  input  logic [NUM_FIELDS-1:0]       osd_writer_field_mask,
  input  logic [NUM_FIELDS*VAL_W-1:0] osd_writer_values,
  input  logic                        v_wr_ready,
  output logic                        v_we,
  output logic [WIDTH_BITS-1:0]       v_wr_addr,
  output logic [7:0]                  v_wr_data,
  output logic                        osd_writer_busy,
  output logic                        osd_writer_done
);

  localparam int DIGITS = VAL_W / 4;
  localparam int TOTAL  = COLS * ROWS;
  localparam int FW     = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int DW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [WIDTH_BITS-1:0] LAST_ADDR = WIDTH_BITS'(TOTAL - 1);
  localparam logic [DW-1:0]         LAST_DIG  = DW'(DIGITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_FIELDS, S_DONE} state_t;

  state_t                      r_state;
  logic                        r_we;
  logic [WIDTH_BITS-1:0]       r_addr;
  logic [7:0]                  r_data;
  logic                        r_busy;
  logic                        r_done;
  logic [7:0]                  r_char;
  logic [NUM_FIELDS-1:0]       r_mask;
  logic [NUM_FIELDS*VAL_W-1:0] r_values;
  logic [FW-1:0]               r_field;
  logic [DW-1:0]               r_digit;

  logic [NUM_FIELDS-1:0]       w_mask_src;
  logic [FW:0]                 w_first;
  logic [FW:0]                 w_next;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Lowest set mask bit at index >= lo; MSB of the result flags "found".
  function automatic logic [FW:0] first_from(input logic [NUM_FIELDS-1:0] m, input int lo);
    logic [FW:0] res;
    res = '0;
    for (int j = NUM_FIELDS - 1; j >= 0; j--) begin
      if (j >= lo && m[j]) res = {1'b1, FW'(j)};
    end
    return res;
  endfunction

  function automatic logic [WIDTH_BITS-1:0] field_addr(input int f, input int d);
    return WIDTH_BITS'((FIELD_ROW + f) * COLS + FIELD_COL + d);
  endfunction

  function automatic logic [7:0] digit_char(input logic [NUM_FIELDS*VAL_W-1:0] vals,
                                            input int f, input int d);
    return hex_char(vals[f*VAL_W + VAL_W - 4 - 4*d +: 4]);
  endfunction

  // In IDLE the first field is looked up from the live inputs being snapshotted.
  assign w_mask_src = (r_state == S_IDLE) ? osd_writer_field_mask : r_mask;
  assign w_first    = first_from(w_mask_src, 0);
  assign w_next     = first_from(r_mask, int'(r_field) + 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_data   <= 8'h00;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_char   <= 8'h00;
      r_mask   <= '0;
      r_values <= '0;
      r_field  <= '0;
      r_digit  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (osd_writer_start_init) begin
            r_char   <= osd_writer_clear_char;
            r_mask   <= osd_writer_field_mask;
            r_values <= osd_writer_values;
            r_busy   <= 1'b1;
            if (osd_writer_clear_en) begin
              r_state <= S_CLEAR;
              r_we    <= 1'b1;
              r_addr  <= '0;
              r_data  <= osd_writer_clear_char;
            end else if (w_first[FW]) begin
              r_state <= S_FIELDS;
              r_we    <= 1'b1;
              r_field <= w_first[FW-1:0];
              r_digit <= '0;
              r_addr  <= field_addr(int'(w_first[FW-1:0]), 0);
              r_data  <= digit_char(osd_writer_values, int'(w_first[FW-1:0]), 0);
            end else begin
              // Empty sequence: one busy cycle with no write, then DONE.
              r_state <= S_FIELDS;
              r_we    <= 1'b0;
            end
          end
        end
        S_CLEAR: begin
          if (v_wr_ready) begin
            if (r_addr == LAST_ADDR) begin
              if (w_first[FW]) begin
                r_state <= S_FIELDS;
                r_field <= w_first[FW-1:0];
                r_digit <= '0;
                r_addr  <= field_addr(int'(w_first[FW-1:0]), 0);
                r_data  <= digit_char(r_values, int'(w_first[FW-1:0]), 0);
              end else begin
                r_state <= S_DONE;
                r_we    <= 1'b0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end else begin
              r_addr <= r_addr + WIDTH_BITS'(1);
            end
          end
        end
        S_FIELDS: begin
          if (!r_we) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (v_wr_ready) begin
            if (r_digit != LAST_DIG) begin
              r_digit <= r_digit + DW'(1);
              r_addr  <= r_addr + WIDTH_BITS'(1);
              r_data  <= digit_char(r_values, int'(r_field), int'(r_digit) + 1);
            end else if (w_next[FW]) begin
              r_field <= w_next[FW-1:0];
              r_digit <= '0;
              r_addr  <= field_addr(int'(w_next[FW-1:0]), 0);
              r_data  <= digit_char(r_values, int'(w_next[FW-1:0]), 0);
            end else begin
              r_state <= S_DONE;
              r_we    <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_we    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign v_we            = r_we;
  assign v_wr_addr       = r_addr;
  assign v_wr_data       = r_data;
  assign osd_writer_busy = r_busy;
  assign osd_writer_done = r_done;

endmodule
